// File: rtl/imem_loader.sv
// Boot loader: unpacks a framed little-endian byte stream into 32-bit instruction-memory writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int WORDS      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  load_start,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  mem_write_enable,
    output logic                  cpu_rst_n,
    output logic                  done,
    output logic                  error
);

    // S_FINISH lets the last write strobe land before done and cpu_rst_n rise.
    typedef enum logic [2:0] {
        S_HDR_LO = 3'd0,
        S_HDR_HI = 3'd1,
        S_DATA   = 3'd2,
        S_FINISH = 3'd3,
        S_DONE   = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_ERROR  = 3'd5,
        S_CHECK  = 3'd6
`else
        S_ERROR  = 3'd5
`endif
    } state_t;

    localparam logic [15:0] WORDS_W = 16'(WORDS);

    state_t                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           lanes_q, lanes_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  xfer;
    logic [15:0]           hdr_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HDR_LO;
            count_q     <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            lanes_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            lanes_q     <= lanes_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    always_comb begin
        in_ready = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) || (state_q == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state_q == S_CHECK) begin
            in_ready = 1'b1;
        end
`endif
    end

    assign xfer      = in_valid && in_ready;
    assign hdr_count = {in_data, count_q[7:0]};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        lanes_d    = lanes_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_HDR_LO: begin
                if (xfer) begin
                    count_d[7:0] = in_data;
                    state_d      = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (xfer) begin
                    count_d = hdr_count;
                    if (hdr_count > WORDS_W) begin
                        state_d = S_ERROR;
                    end else if (hdr_count == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: lanes_d[7:0]   = in_data;
                        2'd1: lanes_d[15:8]  = in_data;
                        2'd2: lanes_d[23:16] = in_data;
                        default: begin
                            wdata_d    = {in_data, lanes_q};
                            addr_d     = word_idx_q[ADDR_WIDTH-1:0];
                            we_d       = 1'b1;
                            word_idx_d = word_idx_q + 16'd1;
                            if (word_idx_q == count_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_d = S_CHECK;
`else
                                state_d = S_FINISH;
`endif
                            end
                        end
                    endcase
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_FINISH: begin
                state_d = S_DONE;
            end
            S_DONE, S_ERROR: begin
                if (load_start) begin
                    state_d    = S_HDR_LO;
                    count_d    = '0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    lanes_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            default: begin
                state_d = S_HDR_LO;
            end
        endcase
    end

    // Status flags follow the next state so they rise together with the state change.
    assign done_d      = (state_d == S_DONE);
    assign cpu_rst_n_d = (state_d == S_DONE);
    assign error_d     = (state_d == S_ERROR);

    assign mem_address      = addr_q;
    assign mem_write_data   = wdata_q;
    assign mem_write_enable = we_q;
    assign cpu_rst_n        = cpu_rst_n_q;
    assign done             = done_q;
    assign error            = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed/randomised bench for imem_loader: frames are built from word lists and the
// observed write strobes and status timing are compared against those lists.
module tb_imem_loader;
    localparam int AW    = 6;
    localparam int WORDS = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          load_start;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic          mem_write_enable;
    logic          cpu_rst_n;
    logic          done;
    logic          error;

    imem_loader #(.ADDR_WIDTH(AW), .WORDS(WORDS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .load_start       (load_start),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .cpu_rst_n        (cpu_rst_n),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/status monitor, sampled on the falling edge.
    int          obs_cyc[$];
    int          obs_addr[$];
    logic [31:0] obs_data[$];
    int          done_rise_q[$];
    int          err_rise_q[$];
    int          double_we = 0;
    logic        we_prev   = 1'b0;
    logic        done_prev = 1'b0;
    logic        err_prev  = 1'b0;

    always @(negedge clk) begin
        if (mem_write_enable) begin
            obs_cyc.push_back(cyc);
            obs_addr.push_back(int'(mem_address));
            obs_data.push_back(mem_write_data);
        end
        if (mem_write_enable && we_prev) double_we <= double_we + 1;
        if (done && !done_prev) done_rise_q.push_back(cyc);
        if (error && !err_prev) err_rise_q.push_back(cyc);
        we_prev   <= mem_write_enable;
        done_prev <= done;
        err_prev  <= error;
    end

    logic [31:0] frame_words[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one byte after 'gap' idle cycles; acc = cycle number of the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
        acc = -1;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                acc = cyc;
                break;
            end
            tick();
        end
        check("byte_accepted", 64'(acc >= 0), 64'd1);
    endtask

    function automatic int first_rise(input bit is_done, input int t0);
        int r = -1;
        if (is_done) begin
            foreach (done_rise_q[i]) if (r < 0 && done_rise_q[i] >= t0) r = done_rise_q[i];
        end else begin
            foreach (err_rise_q[i]) if (r < 0 && err_rise_q[i] >= t0) r = err_rise_q[i];
        end
        return r;
    endfunction

    task automatic pulse_load_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("restart_done", 64'(done), 64'd0);
        check("restart_error", 64'(error), 64'd0);
        check("restart_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("restart_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic run_frame(input int n_hdr, input int gap_max, input bit bad_csum);
        int          base_w = obs_addr.size();
        int          t0     = cyc;
        int          acc4[$];
        int          acc;
        int          hdr_acc;
        int          end_acc;
        bit          expect_ok = 1'b1;
        logic [15:0] nh = 16'(n_hdr);
        logic [7:0]  xs = 8'h00;
        logic [31:0] w;
        logic [7:0]  b;

        send_byte(nh[7:0], $urandom_range(0, gap_max), acc);
        send_byte(nh[15:8], $urandom_range(0, gap_max), hdr_acc);
        if (n_hdr > WORDS) begin
            in_valid = 1'b0;
            repeat (4) tick();
            check("oversize_error", 64'(error), 64'd1);
            check("oversize_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
            check("oversize_in_ready", 64'(in_ready), 64'd0);
            check("oversize_done", 64'(done), 64'd0);
            check("oversize_no_writes", 64'(obs_addr.size()), 64'(base_w));
            check("oversize_error_time", 64'(first_rise(1'b0, t0)), 64'(hdr_acc));
            return;
        end
        for (int i = 0; i < n_hdr; i++) begin
            w = frame_words[i];
            for (int j = 0; j < 4; j++) begin
                b  = w[8*j +: 8];
                xs = xs ^ b;
                send_byte(b, $urandom_range(0, gap_max), acc);
                if (j == 3) acc4.push_back(acc);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? (xs ^ 8'h5A) : xs, $urandom_range(0, gap_max), end_acc);
        expect_ok = !bad_csum;
`else
        end_acc = (n_hdr > 0) ? acc4[n_hdr-1] + 1 : hdr_acc;
        expect_ok = 1'b1;
        if (bad_csum) $display("note: checksum disabled, bad_csum ignored");
`endif
        in_valid = 1'b0;
        repeat (4) tick();

        check("write_count", 64'(obs_addr.size() - base_w), 64'(n_hdr));
        for (int i = 0; i < n_hdr && base_w + i < obs_addr.size(); i++) begin
            check("write_addr", 64'(obs_addr[base_w+i]), 64'(i));
            check("write_data", 64'(obs_data[base_w+i]), 64'(frame_words[i]));
            check("write_latency", 64'(obs_cyc[base_w+i]), 64'(acc4[i]));
            $display("write %0d addr=%0d data=%08h cyc=%0d", i, obs_addr[base_w+i], obs_data[base_w+i], obs_cyc[base_w+i]);
        end
        check("strobe_single_cycle", 64'(double_we), 64'd0);
        check("final_done", 64'(done), 64'(expect_ok));
        check("final_cpu_rst_n", 64'(cpu_rst_n), 64'(expect_ok));
        check("final_error", 64'(error), 64'(!expect_ok));
        check("final_in_ready", 64'(in_ready), 64'd0);
        check(expect_ok ? "done_time" : "error_time", 64'(first_rise(expect_ok, t0)), 64'(end_acc));
        $display("frame n=%0d gap_max=%0d done=%0b error=%0b", n_hdr, gap_max, done, error);
    endtask

    initial begin
        int acc;
        rst_n      = 1'b1;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        load_start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_we", 64'(mem_write_enable), 64'd0);
        check("reset_addr", 64'(mem_address), 64'd0);
        check("reset_data", 64'(mem_write_data), 64'd0);
        check("reset_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_error", 64'(error), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        frame_words = '{32'h00000513, 32'h00100093};
        run_frame(2, 0, 1'b0);

        pulse_load_start();
        run_frame(WORDS + 1, 0, 1'b0);

        pulse_load_start();
        run_frame(2, 5, 1'b0);

        pulse_load_start();
        frame_words = {};
        for (int i = 0; i < WORDS; i++) frame_words.push_back($urandom);
        run_frame(WORDS, 1, 1'b0);

        pulse_load_start();
        run_frame(0, 2, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_load_start();
        frame_words = '{32'h00000513, 32'h00100093};
        run_frame(2, 1, 1'b1);
        pulse_load_start();
        run_frame(2, 1, 1'b0);
`endif

        for (int r = 0; r < 3; r++) begin
            int n = $urandom_range(1, 8);
            pulse_load_start();
            frame_words = {};
            for (int i = 0; i < n; i++) frame_words.push_back($urandom);
            run_frame(n, 3, 1'b0);
        end

        // Abort a load after 5 payload bytes; outputs must clear without a clock edge.
        pulse_load_start();
        send_byte(8'h02, 0, acc);
        send_byte(8'h00, 0, acc);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), 0, acc);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_we", 64'(mem_write_enable), 64'd0);
        check("abort_addr", 64'(mem_address), 64'd0);
        check("abort_data", 64'(mem_write_data), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        frame_words = '{$urandom};
        run_frame(1, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
